// File: rtl/btn_pkg.sv
// btn_pkg: shared defaults, counter-width helper and vector type for the push-button input stage.
package btn_pkg;
    localparam int BTN_NUM              = 4;
    localparam int BTN_DEBOUNCE_DEFAULT = 250000;
    localparam int BTN_REPEAT_DEFAULT   = 12500000;

    typedef logic [BTN_NUM-1:0] btn_vec_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: synchronise, debounce and edge-detect one active-low button, with toggle latch.
// Auto-repeat of press_pulse is built only when BTN_AUTOREPEAT_EN is defined.
module debounce_cell import btn_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
`ifdef BTN_AUTOREPEAT_EN
    , parameter int REPEAT_CYCLES = BTN_REPEAT_DEFAULT
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic bt_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1, sync2, stable_n;
    logic [CW-1:0] cnt;
    logic          accept, rep_fire, fire;

    assign accept  = (sync2 != stable_n) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign fire    = (accept && !sync2) || rep_fire;
    assign pressed = ~stable_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            stable_n      <= 1'b1;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            toggle        <= 1'b0;
        end else begin
            sync1         <= bt_n;
            sync2         <= sync1;
            cnt           <= (sync2 == stable_n || accept) ? '0 : cnt + 1'b1;
            stable_n      <= accept ? sync2 : stable_n;
            press_pulse   <= fire;
            release_pulse <= accept && sync2;
            toggle        <= fire ? ~toggle : toggle;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = cnt_width(REPEAT_CYCLES);

    logic [RW-1:0] rcnt;

    // A release being accepted this cycle suppresses any repeat that would coincide with it.
    assign rep_fire = !stable_n && !accept && (rcnt == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rcnt <= '0;
        else
            rcnt <= (stable_n || fire) ? '0 : rcnt + 1'b1;
    end
`else
    assign rep_fire = 1'b0;
`endif
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: NUM_BT independent debounce cells for the active-low board buttons.
// Optional auto-repeat of press pulses via BTN_AUTOREPEAT_EN.
module button_conditioner import btn_pkg::*; #(
    parameter int NUM_BT          = BTN_NUM,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int REPEAT_CYCLES   = BTN_REPEAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_BT-1:0] bt_n,
    output logic [NUM_BT-1:0] pressed,
    output logic [NUM_BT-1:0] press_pulse,
    output logic [NUM_BT-1:0] release_pulse,
    output logic [NUM_BT-1:0] toggle
);
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20) || REPEAT_CYCLES < 2) begin : g_bad_cfg
        $error("button_conditioner: DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
    end

    genvar i;
    for (i = 0; i < NUM_BT; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .bt_n         (bt_n[i]),
            .pressed      (pressed[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .toggle       (toggle[i])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and randomised checks of button_conditioner against a history-window model.
module tb_button_conditioner;
    localparam int N = 4;
    localparam int D = 4;
    localparam int R = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] bt_n = '1;
    logic [N-1:0] pressed, press_pulse, release_pulse, toggle;

    int n_chk  = 0;
    int n_fail = 0;

    button_conditioner #(.NUM_BT(N), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .clk(clk), .rst(rst), .bt_n(bt_n), .pressed(pressed),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .toggle(toggle)
    );

    always #5 clk = ~clk;

    // Model: a level is accepted once the last D synchronised observations (raw samples
    // delayed by two edges) all differ from the accepted level.
    logic [N-1:0] hist [0:D];
    logic [N-1:0] m_stable_n, m_pp, m_rp, m_tog;
    int           edge_k;
    int           press_edge [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j <= D; j++) hist[j] = '1;
            m_stable_n = '1; m_pp = '0; m_rp = '0; m_tog = '0; edge_k = 0;
            for (int i = 0; i < N; i++) press_edge[i] = 0;
        end else begin
            edge_k++;
            m_pp = '0;
            m_rp = '0;
            for (int i = 0; i < N; i++) begin
                bit acc;
                acc = 1'b1;
                for (int j = 1; j <= D; j++) if (hist[j][i] == m_stable_n[i]) acc = 1'b0;
                if (acc) begin
                    m_stable_n[i] = ~m_stable_n[i];
                    if (!m_stable_n[i]) begin
                        m_pp[i] = 1'b1;
                        m_tog[i] = ~m_tog[i];
                        press_edge[i] = edge_k;
                    end else
                        m_rp[i] = 1'b1;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (!m_stable_n[i] && ((edge_k - press_edge[i]) % R == 0)) begin
                    m_pp[i] = 1'b1;
                    m_tog[i] = ~m_tog[i];
                end
`endif
            end
            for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = bt_n;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_chk += 4;
            if (pressed !== ~m_stable_n) begin
                n_fail++; $display("FAIL model_pressed t=%0t got=%b want=%b", $time, pressed, ~m_stable_n);
            end
            if (press_pulse !== m_pp) begin
                n_fail++; $display("FAIL model_press_pulse t=%0t got=%b want=%b", $time, press_pulse, m_pp);
            end
            if (release_pulse !== m_rp) begin
                n_fail++; $display("FAIL model_release_pulse t=%0t got=%b want=%b", $time, release_pulse, m_rp);
            end
            if (toggle !== m_tog) begin
                n_fail++; $display("FAIL model_toggle t=%0t got=%b want=%b", $time, toggle, m_tog);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        chk("async_rst_pressed", 32'(pressed), 0);
        chk("async_rst_pp", 32'(press_pulse), 0);
        chk("async_rst_toggle", 32'(toggle), 0);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        chk("reset_pressed", 32'(pressed), 0);
        chk("reset_toggle", 32'(toggle), 0);
        step(20);
        chk("idle_pressed", 32'(pressed), 0);

        bt_n[0] = 1'b0;
        step(5);
        chk("t2_not_yet", 32'(pressed[0]), 0);
        step(1);
        chk("t2_pressed", 32'(pressed), 32'h1);
        chk("t2_pulse", 32'(press_pulse), 32'h1);
        chk("t2_toggle", 32'(toggle), 32'h1);
        step(1);
        chk("t2_pulse_gone", 32'(press_pulse), 0);

        async_reset();
        step(5);
        chk("t2_requal_wait", 32'(pressed[0]), 0);
        step(1);
        chk("t2_requal_pressed", 32'(pressed[0]), 1);
        chk("t2_requal_pulse", 32'(press_pulse[0]), 1);
        bt_n[0] = 1'b1;
        step(10);

        bt_n[1] = 1'b0; step(3);
        bt_n[1] = 1'b1; step(1);
        bt_n[1] = 1'b0;
        chk("t3_glitch_quiet", 32'(pressed[1]), 0);
        step(5);
        chk("t3_wait", 32'(pressed[1]), 0);
        step(1);
        chk("t3_pressed", 32'(pressed[1]), 1);
        bt_n[1] = 1'b1;
        step(10);

        for (int r = 0; r < 2; r++) begin
            bt_n[2] = 1'b0;
            step(6);
            chk("t4_press_pulse", 32'(press_pulse[2]), 1);
`ifndef BTN_AUTOREPEAT_EN
            chk("t4_toggle", 32'(toggle[2]), (r == 0) ? 1 : 0);
`endif
            step(4);
            bt_n[2] = 1'b1;
            step(5);
            chk("t4_rel_wait", 32'(release_pulse[2]), 0);
            step(1);
            chk("t4_release_pulse", 32'(release_pulse[2]), 1);
            chk("t4_released", 32'(pressed[2]), 0);
            step(4);
        end

        bt_n = '0;
        step(6);
        chk("t5_all_pulse", 32'(press_pulse), 32'hF);
        async_reset();
        step(6);
        chk("t5_requal_pulse", 32'(press_pulse), 32'hF);
        bt_n = '1;
        step(12);

        async_reset();
        bt_n[0] = 1'b0;
        step(6);
        chk("t6_first_pulse", 32'(press_pulse[0]), 1);
        begin
            int np;
            int ok;
            np = 0; ok = 1;
            for (int c = 1; c <= 30; c++) begin
                step(1);
                if (press_pulse[0]) begin
                    np++;
                    if (c % R != 0) ok = 0;
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            chk("t6_repeat_count", np, 3);
            chk("t6_repeat_spacing", ok, 1);
            chk("t6_toggle_end", 32'(toggle[0]), 0);
`else
            chk("t6_single_pulse", np, 0);
            chk("t6_toggle_end", 32'(toggle[0]), 1);
`endif
        end
        bt_n = '1;
        step(10);

        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) bt_n[i] = ~bt_n[i];
            if ($urandom_range(0, 599) == 0) async_reset();
            else step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
